sobel_pixel_fetch: RTL and testbench
====================================

Name: sobel_pixel_fetch

Overview:
- Avalon-MM read sequencer directly downstream of the slave address decoder.
- Consumes the decoder's startpixel, endpixel and control registers, and produces the status word the decoder returns on reads.
- On a start command it walks the pixel address range and issues one Avalon-MM read per pixel. Each returned word is forwarded to the Sobel window buffer over a valid/ready stream.

Parameters:
- ADDR_STEP, 4, byte increment between consecutive pixel addresses (power of two, ≥1).
- DATA_W, 32, width of the read data and the pixel stream.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- startpixel  in  32  first pixel byte address (inclusive).
- endpixel  in  32  last pixel byte address (inclusive).
- control  in  32  bit0 = start (acts on a 0→1 edge), bit1 = abort (level); other bits ignored.
- status  out  32  bit0 busy, bit1 done, bit2 error, bits[31:16] pixels delivered (low 16 bits of the count).
- m_address  out  32  Avalon master read address.
- m_read  out  1  Avalon read request.
- m_waitrequest  in  1  slave stall.
- m_readdata  in  DATA_W  read data.
- m_readdatavalid  in  1  read data qualifier.
- pix_data  out  DATA_W  pixel to the window buffer.
- pix_valid  out  1  pix_data is valid.
- pix_ready  in  1  downstream can accept.

Behaviour:
- Reset (rst high at a clk edge) clears all of the following, in any state, mid-transfer included:
  - outputs: status = 0, m_address = 0, m_read = 0, pix_valid = 0, pix_data = 0;
  - internal state: state = IDLE, start-edge register = 0.
- A read already in flight when reset hits is discarded; a late m_readdatavalid seen in IDLE is ignored.
- Start edge: registered copy of control[0]; start_evt = control[0] & ~prev.
- States:
  - IDLE:
    - On start_evt, latch startpixel into cur_addr and endpixel into last_addr, and clear done, error and the count.
    - If endpixel < startpixel (unsigned): set error=1 and done=1, stay in IDLE, issue no reads.
    - Otherwise set busy=1 and go to REQ.
  - REQ:
    - m_read=1 and m_address=cur_addr.
    - Hold both stable while m_waitrequest=1.
    - On the first cycle with m_waitrequest=0, the request is accepted: drop m_read the next cycle and go to RESP.
  - RESP:
    - Wait for m_readdatavalid; capture m_readdata into pix_data, set pix_valid=1, go to PUSH.
    - Only one read is ever outstanding.
  - PUSH:
    - Hold pix_data and pix_valid until pix_ready=1. That cycle is the transfer: count += 1.
    - If cur_addr == last_addr: busy=0, done=1, go to IDLE.
    - Else: cur_addr += ADDR_STEP and go to REQ. The new request is asserted on the next cycle.
- The address adds ADDR_STEP modulo 2^32. Completion is tested by equality before incrementing.
  - If (endpixel − startpixel) is not a multiple of ADDR_STEP, the last issued address is the largest address ≤ endpixel. Termination is triggered when cur_addr + ADDR_STEP > last_addr or the add wraps.
- Abort (control[1]=1):
  - Checked in REQ only after the request is accepted (m_waitrequest=0), or with m_read still low.
  - Checked in RESP and PUSH at any cycle.
  - Effect: return to IDLE, busy=0, done=0, error=0, pix_valid=0, m_read=0.
  - An outstanding response arriving after an abort is dropped.
- start_evt while busy is ignored. Changes to startpixel/endpixel during a run have no effect.
- status is registered: it reflects state one cycle after the causing edge.
- done stays 1 until the next start_evt or reset. The count saturates at 0xFFFF in the status field.
- Minimum pixel period: 3 cycles (REQ → RESP → PUSH) with zero-wait slave, data valid the cycle after acceptance, and pix_ready held high.

Test Plan:
- Basic run: startpixel=0x100, endpixel=0x10C, pulse control[0], zero-wait slave returning addr^0xA5A5A5A5, pix_ready=1 → addresses 0x100, 0x104, 0x108, 0x10C, each exactly once.
  - The 4 pixels carry the matching data.
  - Final status = 0x0004_0002 (count 4, done).
- Backpressure: same range, m_waitrequest high 3 cycles per read, pix_ready low 5 cycles on pixel 2 → m_address/m_read and pix_data/pix_valid held stable throughout the stalls; no pixel lost or duplicated.
- Error: startpixel=0x200, endpixel=0x1FC, start → no m_read ever asserted; status = 0x0000_0006 next cycle.
- Single pixel plus held start: start=end=0x40, control[0] held high 10 cycles → exactly one read; count=1; no restart while start is held.
- Abort: 8-pixel run, raise control[1] during the 3rd RESP → busy drops and status = 0x0002_0000 (2 pixels delivered, done=0, error=0).
  - The late readdatavalid produces no pix_valid.
  - A new start afterwards runs from startpixel cleanly.
- Reset mid-PUSH: assert rst with pix_valid=1 → next cycle all outputs are 0 and the state is IDLE; no read is issued until a fresh start edge.

Source files
------------

// File: rtl/sobel_pixel_fetch_if.sv
// Avalon-MM read master and pixel stream signals between the fetch sequencer,
// the memory slave and the Sobel window buffer.
interface sobel_pixel_fetch_if #(
    parameter int unsigned DATA_W = 32
);
    logic [31:0]       m_address;
    logic              m_read;
    logic              m_waitrequest;
    logic [DATA_W-1:0] m_readdata;
    logic              m_readdatavalid;
    logic [DATA_W-1:0] pix_data;
    logic              pix_valid;
    logic              pix_ready;

    modport master (
        output m_address, m_read, pix_data, pix_valid,
        input  m_waitrequest, m_readdata, m_readdatavalid, pix_ready
    );

    modport slave (
        input  m_address, m_read, pix_data, pix_valid,
        output m_waitrequest, m_readdata, m_readdatavalid, pix_ready
    );
endinterface

// File: rtl/sobel_pixel_fetch.sv
// Pixel read sequencer: walks [startpixel, endpixel] issuing one Avalon read per
// pixel, forwarding each returned word on a valid/ready stream.
module sobel_pixel_fetch #(
    parameter int unsigned ADDR_STEP = 4,
    parameter int unsigned DATA_W    = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] startpixel,
    input  logic [31:0] endpixel,
    input  logic [31:0] control,
    output logic [31:0] status,
    sobel_pixel_fetch_if.master bus
);
    localparam int unsigned AW = 32;
    localparam int unsigned CW = 16;

    typedef enum logic [1:0] {IDLE, REQ, RESP, PUSH} state_e;

    state_e            state_q, state_d;
    logic              start_prev_q;
    logic [AW-1:0]     cur_addr_q, cur_addr_d;
    logic [AW-1:0]     last_addr_q, last_addr_d;
    logic [AW-1:0]     m_address_q, m_address_d;
    logic              m_read_q, m_read_d;
    logic [DATA_W-1:0] pix_data_q, pix_data_d;
    logic              pix_valid_q, pix_valid_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [CW-1:0]     count_q, count_d;

    logic              start_evt_c;
    logic              abort_c;
    logic              range_err_c;
    logic [AW:0]       next_addr_c;
    logic              last_pix_c;
    logic              unused_ctrl;

    assign start_evt_c = control[0] & ~start_prev_q;
    assign abort_c     = control[1];
    assign range_err_c = endpixel < startpixel;
    assign unused_ctrl = ^control[31:2];

    // Run ends on the exact last address, on overshoot past it, or on address wrap.
    assign next_addr_c = {1'b0, cur_addr_q} + (AW+1)'(ADDR_STEP);
    assign last_pix_c  = (cur_addr_q == last_addr_q) || next_addr_c[AW] ||
                         (next_addr_c[AW-1:0] > last_addr_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start_evt_c && !range_err_c) state_d = REQ;
            REQ:  if (!bus.m_waitrequest) state_d = abort_c ? IDLE : RESP;
            RESP: begin
                if (abort_c)                  state_d = IDLE;
                else if (bus.m_readdatavalid) state_d = PUSH;
            end
            PUSH: begin
                if (abort_c)            state_d = IDLE;
                else if (bus.pix_ready) state_d = last_pix_c ? IDLE : REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_addr_d  = cur_addr_q;
        last_addr_d = last_addr_q;
        m_address_d = m_address_q;
        m_read_d    = m_read_q;
        pix_data_d  = pix_data_q;
        pix_valid_d = pix_valid_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        count_d     = count_q;
        case (state_q)
            IDLE: begin
                if (start_evt_c) begin
                    cur_addr_d  = startpixel;
                    last_addr_d = endpixel;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    count_d     = '0;
                    if (range_err_c) begin
                        error_d = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        busy_d      = 1'b1;
                        m_read_d    = 1'b1;
                        m_address_d = startpixel;
                    end
                end
            end
            REQ: begin
                if (!bus.m_waitrequest) begin
                    m_read_d = 1'b0;
                    if (abort_c) begin
                        busy_d  = 1'b0;
                        done_d  = 1'b0;
                        error_d = 1'b0;
                    end
                end
            end
            RESP: begin
                if (abort_c) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end else if (bus.m_readdatavalid) begin
                    pix_data_d  = bus.m_readdata;
                    pix_valid_d = 1'b1;
                end
            end
            PUSH: begin
                if (abort_c) begin
                    busy_d      = 1'b0;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    pix_valid_d = 1'b0;
                end else if (bus.pix_ready) begin
                    pix_valid_d = 1'b0;
                    if (count_q != {CW{1'b1}}) count_d = count_q + CW'(1);
                    if (last_pix_c) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        cur_addr_d  = next_addr_c[AW-1:0];
                        m_address_d = next_addr_c[AW-1:0];
                        m_read_d    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            start_prev_q <= 1'b0;
            cur_addr_q   <= '0;
            last_addr_q  <= '0;
            m_address_q  <= '0;
            m_read_q     <= 1'b0;
            pix_data_q   <= '0;
            pix_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
            count_q      <= '0;
        end else begin
            start_prev_q <= control[0];
            cur_addr_q   <= cur_addr_d;
            last_addr_q  <= last_addr_d;
            m_address_q  <= m_address_d;
            m_read_q     <= m_read_d;
            pix_data_q   <= pix_data_d;
            pix_valid_q  <= pix_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
            count_q      <= count_d;
        end
    end

    assign bus.m_address = m_address_q;
    assign bus.m_read    = m_read_q;
    assign bus.pix_data  = pix_data_q;
    assign bus.pix_valid = pix_valid_q;
    assign status        = {count_q, 13'd0, error_q, done_q, busy_q};

endmodule

// File: tb/tb_sobel_pixel_fetch.sv
// Directed bench for sobel_pixel_fetch with a reactive Avalon slave and pixel sink.
module tb_sobel_pixel_fetch;
    localparam int unsigned DATA_W = 32;
    localparam logic [31:0] KEY    = 32'hA5A5_A5A5;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] startpixel, endpixel, control, status;

    sobel_pixel_fetch_if #(.DATA_W(DATA_W)) bus ();

    sobel_pixel_fetch #(.ADDR_STEP(4), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .startpixel (startpixel),
        .endpixel   (endpixel),
        .control    (control),
        .status     (status),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Test knobs (written by the stimulus only)
    int wait_n = 0;
    int resp_delay = 0;
    int hold_idx = -1;
    int hold_len = 0;
    bit mon_en = 1'b1;

    // Slave / sink / monitor state (written by the negedge process only)
    int          stall_ctr = 0;
    int          hold_cnt = 0;
    int          rd_cycles = 0;
    int          wr_cycles = 0;
    int          ready_low = 0;
    int          stab_err = 0;
    bit          pend = 1'b0;
    int          pend_cnt = 0;
    logic [31:0] pend_addr = '0;
    bit          prev_stall_rd = 1'b0;
    bit          prev_stall_pix = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] prev_pix = '0;
    logic [31:0] acc_q[$];
    logic [31:0] rx_q[$];

    // Snapshot bases per run
    int acc_b, rx_b, rd_b, wr_b, rl_b, se_b;

    always @(negedge clk) begin
        if (mon_en) begin
            if (prev_stall_rd && (bus.m_read !== 1'b1 || bus.m_address !== prev_addr)) stab_err++;
            if (prev_stall_pix && (bus.pix_valid !== 1'b1 || bus.pix_data !== prev_pix)) stab_err++;
        end
        if (bus.m_read === 1'b1) rd_cycles++;
        bus.m_readdatavalid = 1'b0;
        if (pend) begin
            if (pend_cnt == 0) begin
                bus.m_readdatavalid = 1'b1;
                bus.m_readdata      = pend_addr ^ KEY;
                pend                = 1'b0;
            end else begin
                pend_cnt--;
            end
        end
        bus.m_waitrequest = 1'b0;
        if (bus.m_read === 1'b1 && !pend) begin
            if (stall_ctr < wait_n) begin
                bus.m_waitrequest = 1'b1;
                stall_ctr++;
                wr_cycles++;
            end else begin
                pend      = 1'b1;
                pend_cnt  = resp_delay;
                pend_addr = bus.m_address;
                acc_q.push_back(bus.m_address);
                stall_ctr = 0;
            end
        end
        bus.pix_ready = 1'b1;
        if (bus.pix_valid === 1'b1) begin
            if (rx_q.size() == hold_idx && hold_cnt < hold_len) begin
                bus.pix_ready = 1'b0;
                hold_cnt++;
                ready_low++;
            end else begin
                rx_q.push_back(bus.pix_data);
                hold_cnt = 0;
            end
        end else begin
            hold_cnt = 0;
        end
        prev_stall_rd  = (bus.m_read === 1'b1) && bus.m_waitrequest;
        prev_stall_pix = (bus.pix_valid === 1'b1) && !bus.pix_ready;
        prev_addr      = bus.m_address;
        prev_pix       = bus.pix_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_run();
        acc_b = acc_q.size();
        rx_b  = rx_q.size();
        rd_b  = rd_cycles;
        wr_b  = wr_cycles;
        rl_b  = ready_low;
        se_b  = stab_err;
    endtask

    task automatic start_run(input logic [31:0] sp, input logic [31:0] ep);
        @(negedge clk);
        startpixel = sp;
        endpixel   = ep;
        control    = 32'h1;
        @(negedge clk);
        control    = 32'h0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while (status[0] === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, 32'(status[0]), 32'd0);
    endtask

    task automatic check_run(input logic [31:0] base, input int npix, input string tag);
        check({tag, "_nreq"}, 32'(acc_q.size() - acc_b), 32'(npix));
        check({tag, "_npix"}, 32'(rx_q.size() - rx_b), 32'(npix));
        for (int i = 0; i < npix; i++) begin
            if (acc_b + i < acc_q.size())
                check({tag, "_addr"}, acc_q[acc_b+i], base + 32'(4*i));
            if (rx_b + i < rx_q.size())
                check({tag, "_data"}, rx_q[rx_b+i], (base + 32'(4*i)) ^ KEY);
        end
    endtask

    initial begin
        int n;
        rst = 1'b1;
        control = '0;
        startpixel = '0;
        endpixel = '0;
        repeat (3) @(negedge clk);
        check("rst_status", status, 32'd0);
        check("rst_m_read", 32'(bus.m_read), 32'd0);
        check("rst_m_address", bus.m_address, 32'd0);
        check("rst_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("rst_pix_data", bus.pix_data, 32'd0);
        rst = 1'b0;

        clear_run();
        start_run(32'h100, 32'h10C);
        wait_idle(100, "basic_done");
        check_run(32'h100, 4, "basic");
        check("basic_status", status, 32'h0004_0002);

        clear_run();
        wait_n = 3; hold_idx = rx_q.size() + 1; hold_len = 5;
        start_run(32'h100, 32'h10C);
        wait_idle(300, "bp_done");
        check_run(32'h100, 4, "bp");
        check("bp_status", status, 32'h0004_0002);
        check("bp_wait_cycles", 32'(wr_cycles - wr_b), 32'd12);
        check("bp_ready_low", 32'(ready_low - rl_b), 32'd5);
        check("bp_stable", 32'(stab_err - se_b), 32'd0);
        wait_n = 0; hold_idx = -1; hold_len = 0;

        clear_run();
        start_run(32'h200, 32'h1FC);
        check("err_status", status, 32'h0000_0006);
        repeat (5) @(negedge clk);
        check("err_no_read", 32'(rd_cycles - rd_b), 32'd0);
        check("err_status_hold", status, 32'h0000_0006);

        clear_run();
        @(negedge clk);
        startpixel = 32'h40; endpixel = 32'h40; control = 32'h1;
        repeat (10) @(negedge clk);
        check("single_status", status, 32'h0001_0002);
        check("single_rd_cycles", 32'(rd_cycles - rd_b), 32'd1);
        check_run(32'h40, 1, "single");
        control = 32'h0;
        repeat (3) @(negedge clk);
        check("single_status_hold", status, 32'h0001_0002);

        clear_run();
        resp_delay = 3;
        start_run(32'h300, 32'h31C);
        n = 0;
        while (acc_q.size() - acc_b < 3 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("abort_third_req", 32'(acc_q.size() - acc_b), 32'd3);
        @(negedge clk);
        control = 32'h2;
        @(negedge clk);
        check("abort_status", status, 32'h0002_0000);
        control = 32'h0;
        repeat (8) @(negedge clk);
        check("abort_late_pix", 32'(rx_q.size() - rx_b), 32'd2);
        check("abort_no_more_req", 32'(acc_q.size() - acc_b), 32'd3);
        check("abort_status_hold", status, 32'h0002_0000);
        resp_delay = 0;
        clear_run();
        start_run(32'h300, 32'h30C);
        wait_idle(100, "restart_done");
        check_run(32'h300, 4, "restart");
        check("restart_status", status, 32'h0004_0002);

        clear_run();
        hold_idx = rx_q.size(); hold_len = 50;
        start_run(32'h500, 32'h50C);
        n = 0;
        while (bus.pix_valid !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rstpush_valid", 32'(bus.pix_valid), 32'd1);
        mon_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rstpush_status", status, 32'd0);
        check("rstpush_m_read", 32'(bus.m_read), 32'd0);
        check("rstpush_m_address", bus.m_address, 32'd0);
        check("rstpush_pix_valid", 32'(bus.pix_valid), 32'd0);
        check("rstpush_pix_data", bus.pix_data, 32'd0);
        rst = 1'b0;
        hold_idx = -1; hold_len = 0;
        clear_run();
        repeat (8) @(negedge clk);
        check("rstpush_no_read", 32'(rd_cycles - rd_b), 32'd0);
        check("rstpush_idle_status", status, 32'd0);
        mon_en = 1'b1;
        clear_run();
        start_run(32'h500, 32'h504);
        wait_idle(100, "fresh_done");
        check_run(32'h500, 2, "fresh");
        check("fresh_status", status, 32'h0002_0002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
